// File: rtl/branch_pkg.sv
// Shared RV32I branch definitions: funct3 codes and the branch operation enum.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        OpBeq  = F3_BEQ,
        OpBne  = F3_BNE,
        OpBlt  = F3_BLT,
        OpBge  = F3_BGE,
        OpBltu = F3_BLTU,
        OpBgeu = F3_BGEU
    } branch_op_e;

endpackage

// File: rtl/branch_cmp.sv
// Operand comparator: equality plus signed and unsigned less-than flags.
module branch_cmp #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            eq,
    output logic            lt_s,
    output logic            lt_u
);

    // Bit XLEN-1 acts as the sign bit for the signed compare.
    always_comb begin
        eq   = (rs1 == rs2);
        lt_u = (rs1 < rs2);
        lt_s = ($signed(rs1) < $signed(rs2));
    end

endmodule

// File: rtl/branch_unit.sv
// RV32I conditional-branch resolver with a one-cycle registered copy of the decision.
// Optional taken/not-taken statistics counters enabled by defining BRANCH_STATS_EN.
module branch_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      fun3,
    input  logic            en,
    output logic            out,
    output logic            illegal,
    output logic            out_q,
    output logic            illegal_q
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     taken_cnt,
    output logic [31:0]     nottaken_cnt
`endif
);

    logic eq;
    logic lt_s;
    logic lt_u;

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .rs1  (rs1),
        .rs2  (rs2),
        .eq   (eq),
        .lt_s (lt_s),
        .lt_u (lt_u)
    );

    // Decode funct3 into the taken flag; unknown codes resolve to not-taken and illegal.
    always_comb begin
        out     = 1'b0;
        illegal = 1'b0;
        case (fun3)
            F3_BEQ:  out = eq;
            F3_BNE:  out = ~eq;
            F3_BLT:  out = lt_s;
            F3_BGE:  out = ~lt_s;
            F3_BLTU: out = lt_u;
            F3_BGEU: out = ~lt_u;
            default: begin
                out     = 1'b0;
                illegal = 1'b1;
            end
        endcase
    end

    // Register the decision only while en is high; otherwise clear so nothing stale lingers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else if (en) begin
            out_q     <= out;
            illegal_q <= illegal;
        end else begin
            out_q     <= 1'b0;
            illegal_q <= 1'b0;
        end
    end

`ifdef BRANCH_STATS_EN
    // Count legal enabled branches by outcome; counters wrap freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt    <= 32'd0;
            nottaken_cnt <= 32'd0;
        end else if (en && !illegal) begin
            if (out) begin
                taken_cnt <= taken_cnt + 32'd1;
            end else begin
                nottaken_cnt <= nottaken_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit.
module tb_branch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  fun3;
    logic        en;
    logic        out;
    logic        illegal;
    logic        out_q;
    logic        illegal_q;
`ifdef BRANCH_STATS_EN
    logic [31:0] taken_cnt;
    logic [31:0] nottaken_cnt;
`endif

    int checks = 0;
    int errors = 0;

    branch_unit #(
        .XLEN (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rs1          (rs1),
        .rs2          (rs2),
        .fun3         (fun3),
        .en           (en),
        .out          (out),
        .illegal      (illegal),
        .out_q        (out_q),
        .illegal_q    (illegal_q)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cnt    (taken_cnt),
        .nottaken_cnt (nottaken_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_out;
    logic [7:0] exp_ill;

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        rs1  = 32'd0;
        rs2  = 32'd0;
        fun3 = 3'b000;
        tick();
        check("reset out_q", {31'd0, out_q}, 32'd0);
        check("reset illegal_q", {31'd0, illegal_q}, 32'd0);
        rst = 1'b0;
        tick();

        // Negative rs1 vs small positive rs2, full funct3 sweep.
        rs1     = 32'h8000_0004;
        rs2     = 32'h0000_0006;
        exp_out = 8'b1001_0010;
        exp_ill = 8'b0000_1100;
        for (int i = 0; i < 8; i++) begin
            fun3 = 3'(i);
            #1;
            check($sformatf("sweep out f3=%0d", i), {31'd0, out}, {31'd0, exp_out[i]});
            check($sformatf("sweep illegal f3=%0d", i), {31'd0, illegal}, {31'd0, exp_ill[i]});
        end

        // Equal operands over the six valid codes.
        rs1     = 32'h1234_5678;
        rs2     = 32'h1234_5678;
        exp_out = 8'b1010_0001;
        for (int i = 0; i < 8; i++) begin
            if (i != 2 && i != 3) begin
                fun3 = 3'(i);
                #1;
                check($sformatf("equal out f3=%0d", i), {31'd0, out}, {31'd0, exp_out[i]});
                check($sformatf("equal illegal f3=%0d", i), {31'd0, illegal}, 32'd0);
            end
        end

        // All-ones vs zero: signed -1 < 0, unsigned max > 0.
        rs1 = 32'hFFFF_FFFF;
        rs2 = 32'h0000_0000;
        fun3 = 3'b100; #1; check("ffff BLT", {31'd0, out}, 32'd1);
        fun3 = 3'b110; #1; check("ffff BLTU", {31'd0, out}, 32'd0);
        fun3 = 3'b101; #1; check("ffff BGE", {31'd0, out}, 32'd0);
        fun3 = 3'b111; #1; check("ffff BGEU", {31'd0, out}, 32'd1);

        // Registered path: one-cycle latency, then cleared when en drops.
        en   = 1'b1;
        fun3 = 3'b001;
        rs1  = 32'd1;
        rs2  = 32'd2;
        #1;
        check("bne comb out", {31'd0, out}, 32'd1);
        check("bne out_q before edge", {31'd0, out_q}, 32'd0);
        tick();
        check("bne out_q", {31'd0, out_q}, 32'd1);
        check("bne illegal_q", {31'd0, illegal_q}, 32'd0);
        en = 1'b0;
        tick();
        check("en low out_q", {31'd0, out_q}, 32'd0);

        // Registered illegal.
        en   = 1'b1;
        fun3 = 3'b010;
        tick();
        check("illegal out_q", {31'd0, out_q}, 32'd0);
        check("illegal illegal_q", {31'd0, illegal_q}, 32'd1);

        // Taken cycle, then reset with en still high and a taken branch.
        fun3 = 3'b001;
        tick();
        check("pre-reset out_q", {31'd0, out_q}, 32'd1);
        rst = 1'b1;
        tick();
        check("mid reset out_q", {31'd0, out_q}, 32'd0);
        check("mid reset illegal_q", {31'd0, illegal_q}, 32'd0);
        check("mid reset comb out", {31'd0, out}, 32'd1);
        rst = 1'b0;
        en  = 1'b0;

`ifdef BRANCH_STATS_EN
        rst = 1'b1;
        tick();
        check("stats reset taken", taken_cnt, 32'd0);
        check("stats reset nottaken", nottaken_cnt, 32'd0);
        rst  = 1'b0;
        en   = 1'b1;
        rs1  = 32'd1;
        rs2  = 32'd2;
        fun3 = 3'b001;
        for (int i = 0; i < 3; i++) tick();
        fun3 = 3'b000;
        for (int i = 0; i < 2; i++) tick();
        fun3 = 3'b010;
        tick();
        fun3 = 3'b001;
        en   = 1'b0;
        tick();
        check("stats taken", taken_cnt, 32'd3);
        check("stats nottaken", nottaken_cnt, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- RV32I conditional-branch resolver for the execute stage: compares rs1/rs2 per funct3 and produces a combinational taken flag.
- Also provides a one-cycle registered copy of the decision for the fetch/PC-select stage.
- Flags funct3 codes that are not valid branch encodings.

Parameters:
- XLEN, 32, operand width in bits; only 32 is required to be supported.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rs1  input  XLEN  first source operand.
- rs2  input  XLEN  second source operand.
- fun3  input  3  instruction funct3 field.
- en  input  1  a branch instruction is present this cycle; qualifies the registered outputs only.
- out  output  1  combinational branch-taken result.
- illegal  output  1  combinational; 1 when fun3 is 010 or 011.
- out_q  output  1  registered out, qualified by en.
- illegal_q  output  1  registered illegal, qualified by en.

Behaviour:
- Combinational path (out, illegal): pure function of rs1, rs2 and fun3; no latency; independent of clk, rst and en.
- fun3 encodings for out:
  - 000 BEQ: out = (rs1 == rs2).
  - 001 BNE: out = (rs1 != rs2).
  - 100 BLT: out = signed(rs1) < signed(rs2), two's complement.
  - 101 BGE: out = signed(rs1) >= signed(rs2).
  - 110 BLTU: out = unsigned(rs1) < unsigned(rs2).
  - 111 BGEU: out = unsigned(rs1) >= unsigned(rs2).
  - 010, 011: out = 0 and illegal = 1. For every other code illegal = 0.
- Signed compare uses bit XLEN-1 as the sign bit. Equal operands give BLT=0, BGE=1, BLTU=0, BGEU=1.
- No X propagation: a case default drives out=0 and illegal=1.
- Registered path, on each rising clk edge:
  - rst=1: out_q <= 0, illegal_q <= 0. Reset has priority over en.
  - else en=1: out_q <= out, illegal_q <= illegal.
  - else (en=0): out_q <= 0, illegal_q <= 0. A stale decision is never held.
- Latency is exactly 1 cycle from inputs to out_q/illegal_q.
- Reset asserted mid-stream clears the registered outputs on the next edge. The combinational outputs are unaffected by reset.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, adds outputs taken_cnt [31:0] and nottaken_cnt [31:0].
- On each edge with en=1, rst=0 and illegal=0, exactly one counter increments: taken_cnt if out=1, otherwise nottaken_cnt.
- Illegal cycles increment neither counter.
- Both counters are cleared by rst and wrap modulo 2^32 with no saturation.
- When the macro is undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package branch_pkg holds:
  - the funct3 localparams F3_BEQ=3'b000, F3_BNE=3'b001, F3_BLT=3'b100, F3_BGE=3'b101, F3_BLTU=3'b110, F3_BGEU=3'b111;
  - a typedef enum logic [2:0] branch_op_e over those codes.
- One sub-module, branch_cmp: purely combinational; outputs eq, lt_s and lt_u from rs1/rs2. The top level derives all six conditions from these three flags.

Test Plan:
- rs1=0x80000004, rs2=0x00000006, sweep fun3 000..111 -> out = 0,1,0,0,1,0,0,1 and illegal = 0,0,1,1,0,0,0,0.
- rs1=rs2=0x12345678, sweep the six valid codes -> BEQ=1, BNE=0, BLT=0, BGE=1, BLTU=0, BGEU=1.
- rs1=0xFFFFFFFF, rs2=0x00000000:
  - BLT -> 1; BLTU -> 0; BGE -> 0; BGEU -> 1.
- en=1 with fun3=001, rs1=1, rs2=2 -> out=1 immediately; out_q=1 after one edge. Then en=0 -> out_q=0 after the next edge.
- rst=1 together with en=1 and a taken branch -> out_q=0 and illegal_q=0 after the edge; combinational out stays 1.
- BRANCH_STATS_EN: reset, then 3 taken, 2 not-taken and 1 illegal cycle (fun3=010) with en=1, plus 1 cycle with en=0 -> taken_cnt=3, nottaken_cnt=2.
